// File: rtl/hs4_tx_fifo_if.sv
// Bundle of the write-side and 4-phase bundled-data signals of hs4_tx_fifo.
// The slave modport is the FIFO's view; the master modport is the environment's.
interface hs4_tx_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [CntW-1:0]   count;
  logic              ovf;
  logic [DATA_W-1:0] data;
  logic              req;
  logic              ack;
  logic              snt;
  logic              busy;

  modport master (
    output wr_en, wr_data, ack,
    input  full, count, ovf, data, req, snt, busy
  );

  modport slave (
    input  wr_en, wr_data, ack,
    output full, count, ovf, data, req, snt, busy
  );
endinterface

// File: rtl/hs4_tx_fifo.sv
// Circular TX FIFO feeding a 4-phase bundled-data link; ack arrives asynchronously
// and is synchronized before the handshake FSM uses it.
module hs4_tx_fifo #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  hs4_tx_fifo_if.slave      bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   req_q, req_d;
  logic                   snt_q, snt_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [DATA_W-1:0]      mem_d [DEPTH];

  logic ack_s;
  logic full;
  logic wr_acc;
  logic pop;
  logic busy;

  assign ack_s  = ack_sync_q[SYNC_STAGES-1];
  // full uses the pre-pop count, so a write at the launch edge of a full FIFO is dropped.
  assign full   = (count_q == CntW'(DEPTH));
  assign wr_acc = bus.wr_en & ~full;

  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.ack};
    wr_ptr_d   = wr_acc ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    ovf_d      = ovf_q | (bus.wr_en & full);
    count_d    = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wr_ptr_q] = bus.wr_data;
  end

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ack_sync_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      req_q      <= 1'b0;
      snt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      req_q      <= req_d;
      snt_q      <= snt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (count_q != '0) state_d = StReqHi;
      StReqHi: if (ack_s)         state_d = StReqLo;
      StReqLo: if (!ack_s)        state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    pop    = 1'b0;
    busy   = (state_q != StIdle);
    req_d  = req_q;
    data_d = data_q;
    snt_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop    = 1'b1;
          req_d  = 1'b1;
          data_d = mem_q[rd_ptr_q];
        end
      end
      StReqHi: if (ack_s)  req_d = 1'b0;
      StReqLo: if (!ack_s) snt_d = 1'b1;
      default: req_d = 1'b0;
    endcase
  end

  assign bus.full  = full;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.data  = data_q;
  assign bus.req   = req_q;
  assign bus.snt   = snt_q;
  assign bus.busy  = busy;
endmodule
